// File: rtl/dense_layer_seq.sv
// Time-multiplexed dense layer: one input feature per cycle against a weight row, OUT_SIZE MACs.
// Define DENSE_SEQ_RELU_EN to clamp negative results to zero ahead of saturation.
module dense_layer_seq #(
  parameter int IN_SIZE    = 26,
  parameter int OUT_SIZE   = 64,
  parameter int DATA_IN_W  = 16,
  parameter int DATA_OUT_W = 16,
  parameter int WB_W       = 8,
  parameter int ACC_W      = 32,
  parameter int SHIFT      = 0,
  localparam int AW        = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_SIZE*DATA_IN_W-1:0]   in_data,
  output logic [AW-1:0]                  w_addr,
  input  logic [OUT_SIZE*WB_W-1:0]       w_data,
  input  logic [OUT_SIZE*WB_W-1:0]       b_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_SIZE*DATA_OUT_W-1:0] out_data,
  output logic                           busy
);

  localparam int PROD_W = DATA_IN_W + WB_W;
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    {{(ACC_W-DATA_OUT_W+1){1'b0}}, {(DATA_OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    {{(ACC_W-DATA_OUT_W+1){1'b1}}, {(DATA_OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_POST, S_DONE} state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [AW-1:0]                   r_k;
  logic                            w_last;
  logic signed [DATA_IN_W-1:0]     r_x [IN_SIZE];
  logic signed [ACC_W-1:0]         r_acc [OUT_SIZE];
  logic [OUT_SIZE*DATA_OUT_W-1:0]  r_out;
  logic signed [DATA_IN_W-1:0]     w_x;
  logic signed [PROD_W-1:0]        w_prod [OUT_SIZE];
  logic signed [ACC_W-1:0]         w_prod_ext [OUT_SIZE];

  function automatic logic [DATA_OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    c = v;
    if (v > OUT_MAX) c = OUT_MAX;
    else if (v < OUT_MIN) c = OUT_MIN;
    return c[DATA_OUT_W-1:0];
  endfunction

  function automatic logic [DATA_OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    r = acc >>> SHIFT;
`ifdef DENSE_SEQ_RELU_EN
    if (r[ACC_W-1]) r = '0;
`else
`endif
    return saturate(r);
  endfunction

  assign w_last   = (r_k == AW'(IN_SIZE - 1));
  assign w_x      = r_x[r_k];
  assign out_data = r_out;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus handshake and ROM address; address runs one row ahead of the MAC index
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != S_IDLE);
    w_addr    = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_BIAS;
      end
      S_BIAS: w_next = S_MAC;
      S_MAC: begin
        w_addr = w_last ? AW'(IN_SIZE - 1) : r_k + AW'(1);
        if (w_last) w_next = S_POST;
      end
      S_POST: begin
        w_addr = AW'(IN_SIZE - 1);
        w_next = S_DONE;
      end
      S_DONE: begin
        w_addr    = AW'(IN_SIZE - 1);
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    for (int j = 0; j < OUT_SIZE; j++) begin
      w_prod[j]     = w_x * $signed(w_data[j*WB_W +: WB_W]);
      w_prod_ext[j] = ACC_W'(w_prod[j]);
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      for (int k = 0; k < IN_SIZE; k++) r_x[k] <= in_data[k*DATA_IN_W +: DATA_IN_W];
    end
  end

  // Accumulate: bias load, IN_SIZE MAC cycles, then shift/ReLU/saturate into the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= '0;
      r_out <= '0;
      for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= '0;
    end else begin
      case (r_state)
        S_BIAS: begin
          r_k <= '0;
          for (int j = 0; j < OUT_SIZE; j++)
            r_acc[j] <= ACC_W'($signed(b_data[j*WB_W +: WB_W]));
        end
        S_MAC: begin
          r_k <= r_k + AW'(1);
          for (int j = 0; j < OUT_SIZE; j++) r_acc[j] <= r_acc[j] + w_prod_ext[j];
        end
        S_POST: begin
          for (int j = 0; j < OUT_SIZE; j++)
            r_out[j*DATA_OUT_W +: DATA_OUT_W] <= post_proc(r_acc[j]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dense_layer_seq.md
Name: dense_layer_seq

Overview:
Parametrised, time-multiplexed fully-connected layer for the speech-recognition NN pipeline. It walks the input features one per cycle and runs OUT_SIZE parallel MACs against one weight-memory row per cycle. Bias is applied once, then output shift, optional ReLU and saturation. Valid/ready handshakes on both sides let it chain with preceding and following dense layers.

Parameters:
IN_SIZE, 26, number of input features (weight rows)
OUT_SIZE, 64, number of neurons (weight columns)
DATA_IN_W, 16, signed input element width
DATA_OUT_W, 16, signed output element width
WB_W, 8, signed weight/bias width
ACC_W, 32, signed accumulator width (≥ DATA_IN_W+WB_W+clog2(IN_SIZE)+1)
SHIFT, 0, arithmetic right shift applied to accumulator before saturation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  IN_SIZE*DATA_IN_W  packed signed inputs; element k at [k*DATA_IN_W +: DATA_IN_W]
w_addr  out  $clog2(IN_SIZE) (min 1)  weight row address to synchronous ROM
w_data  in  OUT_SIZE*WB_W  weight row returned one cycle after w_addr; column j at [j*WB_W +: WB_W]
b_data  in  OUT_SIZE*WB_W  static bias vector, same packing
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts output
out_data  out  OUT_SIZE*DATA_OUT_W  packed signed results, same packing as in_data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: clk and rst as already decided (reset rst, synchronous, active-high; clock clk). State=IDLE, out_valid=0, out_data=0, all accumulators=0, w_addr=0, busy=0.
- FSM states: IDLE, BIAS, MAC, POST, DONE.
- IDLE: in_ready=1, w_addr=0. On in_valid&&in_ready, register in_data and go to BIAS.
- BIAS (1 cycle): acc[j] = sign-extend(b_data[j]). w_addr=0 is presented, so row 0 arrives in the first MAC cycle. Go to MAC with k=0.
- MAC (IN_SIZE cycles, k=0..IN_SIZE-1): acc[j] += x[k]*w_data[j]. Product is a full-precision signed DATA_IN_W+WB_W value, sign-extended to ACC_W. Accumulation is modular at ACC_W. w_addr=k+1, held at IN_SIZE-1 on the last cycle. After k=IN_SIZE-1, go to POST.
- POST (1 cycle): r[j] = acc[j] >>> SHIFT (arithmetic shift, floor). Apply optional ReLU. Saturate to [-2^(DATA_OUT_W-1), 2^(DATA_OUT_W-1)-1]. Register the result into out_data. Go to DONE.
- DONE: out_valid=1. out_data is stable and in_ready=0 until out_ready. On out_valid&&out_ready, out_valid falls next cycle and the FSM returns to IDLE. No same-cycle re-accept; in_ready rises the cycle after the output handshake.
- Latency: input handshake at edge E → out_valid high after edge E+IN_SIZE+2. Throughput is one vector per IN_SIZE+4 cycles with out_ready held high.
- in_valid outside IDLE is ignored. in_data is sampled only at the handshake.
- out_data keeps its last value after the output handshake, until the next POST.
- b_data must be stable during BIAS. It is sampled only in BIAS.
- rst mid-operation (any state) returns all state to reset values on the next edge. No partial result is emitted, and no accumulator residue carries into the next vector.

Optional Feature:
DENSE_SEQ_RELU_EN: when defined, POST clamps r[j]<0 to 0 before saturation, so outputs are non-negative. When undefined, signed outputs pass through saturation unchanged.

Test Plan:
- Basic MAC: IN_SIZE=3, OUT_SIZE=2, SHIFT=0, x={1,2,3}, w rows col0={2,3,4}, col1={-1,-1,-1}, bias={5,-1}.
  - Expected out={25,-7}; with DENSE_SEQ_RELU_EN, out={25,0}.
  - out_valid asserts 5 cycles after the input handshake.
- Saturation: DATA_OUT_W=8, x={127,127,127}, col0 w=127, col1 w=-128, bias 0.
  - Expected out0=127 (acc 48387).
  - Expected out1=-128 without ReLU (acc -48768), 0 with ReLU.
- Shift: SHIFT=2 with the basic-MAC stimulus.
  - Expected out0=6 (25>>>2); out1=-2 (floor of -7/4) without ReLU.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid and in_data.
  - out_valid stays 1 with out_data unchanged; in_ready stays 0; w_addr unchanged.
  - Release out_ready: out_valid=0 and in_ready=1 the next cycle.
- Reset mid-MAC: assert rst during MAC cycle k=1.
  - Next cycle: out_valid=0, in_ready=1, busy=0, out_data=0.
  - A following basic-MAC vector yields exactly {25,-7}.
- Back-to-back: 3 vectors with in_valid and out_ready held high.
  - Each result is correct.
  - Successive input handshakes are spaced exactly IN_SIZE+4 cycles apart.
  - w_addr sequence per vector: 0,1,2,2.
